// File: rtl/afe_serial_in_if.sv
// Link-side and consumer-side signal bundle for afe_serial_in.
// The master modport belongs to the driver and consumer; the slave modport belongs to the receiver.
interface afe_serial_in_if #(
  parameter int unsigned WIDTH = 20
);
  logic             enable;
  logic             cs_n;
  logic             mosi;
  logic             data_ack;
  logic [WIDTH-1:0] parallel_output;
  logic             data_valid;
  logic             frame_error;
  logic             overrun;
  logic             busy;

  modport master (
    output enable, cs_n, mosi, data_ack,
    input  parallel_output, data_valid, frame_error, overrun, busy
  );

  modport slave (
    input  enable, cs_n, mosi, data_ack,
    output parallel_output, data_valid, frame_error, overrun, busy
  );
endinterface

// File: rtl/afe_serial_in.sv
// Serial frame receiver. It checks the frame length and holds the last good word until the consumer acknowledges it.
// cs_n is an active-high bit qualifier. A new frame may start only after a cs_n=0 cycle with enable high.
module afe_serial_in #(
  parameter int unsigned WIDTH = 20
) (
  input logic           clk,
  input logic           reset,
  afe_serial_in_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [4:0]       bit_count_q, bit_count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             dvalid_q, dvalid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic start;
  assign start = armed_q & bus.enable & bus.cs_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      bit_count_q <= '0;
      shreg_q     <= '0;
      pout_q      <= '0;
      dvalid_q    <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_count_q <= bit_count_d;
      shreg_q     <= shreg_d;
      pout_q      <= pout_d;
      dvalid_q    <= dvalid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    bit_count_d = bit_count_q;
    shreg_d     = shreg_q;
    pout_d      = pout_q;
    dvalid_d    = dvalid_q;
    ferr_d      = 1'b0;
    ovr_d       = ovr_q;

    if (bus.enable && !bus.cs_n) armed_d = 1'b1;
    if (!bus.enable)             armed_d = 1'b0;

    if (dvalid_q && bus.data_ack) dvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SHIFT;
          armed_d     = 1'b0;
          shreg_d     = {shreg_q[WIDTH-2:0], bus.mosi};
          bit_count_d = 5'd1;
        end
      end

      SHIFT: begin
        if (bus.cs_n) begin
          shreg_d     = {shreg_q[WIDTH-2:0], bus.mosi};
          bit_count_d = (bit_count_q == 5'd31) ? 5'd31 : bit_count_q + 5'd1;
        end else begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (bit_count_q == 5'(WIDTH)) begin
          pout_d   = shreg_q;
          dvalid_d = 1'b1;
          if (dvalid_q && !bus.data_ack) ovr_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
        // A frame that follows a single cs_n=0 gap has its first bit here, so it is started now instead of passing through IDLE.
        if (start) begin
          state_d     = SHIFT;
          armed_d     = 1'b0;
          shreg_d     = {shreg_q[WIDTH-2:0], bus.mosi};
          bit_count_d = 5'd1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (!bus.enable) ovr_d = 1'b0;
  end

  assign bus.parallel_output = pout_q;
  assign bus.data_valid      = dvalid_q;
  assign bus.frame_error     = ferr_q;
  assign bus.overrun         = ovr_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_afe_serial_in.sv
// Directed self-checking bench for afe_serial_in.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_afe_serial_in;

  localparam int unsigned WIDTH = 20;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  afe_serial_in_if #(.WIDTH(WIDTH)) bus ();

  afe_serial_in #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.cs_n = 1'b1;
      bus.mosi = val[i];
      @(negedge clk);
    end
  endtask

  // Sends the bits and then one cs_n=0 cycle, so the receiver is in CHECK when this returns.
  task automatic send_frame(input logic [31:0] val, input int n);
    send_bits(val, n);
    bus.cs_n = 1'b0;
    bus.mosi = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.cs_n     = 1'b0;
    bus.mosi     = 1'b0;
    bus.data_ack = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_pout",  bus.parallel_output, 32'h0);
    chk("rst_dv",    bus.data_valid,      32'h0);
    chk("rst_fe",    bus.frame_error,     32'h0);
    chk("rst_ov",    bus.overrun,         32'h0);
    chk("rst_busy",  bus.busy,            32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame and the two-edge latency after the last bit
    send_frame(32'hA5C3F, 20);
    chk("basic_busy_check", bus.busy,       32'h1);
    chk("basic_dv_e1",      bus.data_valid, 32'h0);
    @(negedge clk);
    chk("basic_pout", bus.parallel_output, 32'hA5C3F);
    chk("basic_dv",   bus.data_valid,      32'h1);
    chk("basic_fe",   bus.frame_error,     32'h0);
    chk("basic_busy", bus.busy,            32'h0);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    chk("ack_dv", bus.data_valid, 32'h0);

    // Short and long frames
    send_frame(32'h12345, 19);
    @(negedge clk);
    chk("short_fe",   bus.frame_error,     32'h1);
    chk("short_pout", bus.parallel_output, 32'hA5C3F);
    chk("short_dv",   bus.data_valid,      32'h0);
    @(negedge clk);
    chk("short_fe_pulse", bus.frame_error, 32'h0);
    send_frame(32'h1ABCDE, 21);
    @(negedge clk);
    chk("long_fe",   bus.frame_error,     32'h1);
    chk("long_pout", bus.parallel_output, 32'hA5C3F);
    chk("long_dv",   bus.data_valid,      32'h0);
    @(negedge clk);
    chk("long_fe_pulse", bus.frame_error, 32'h0);

    // Overwrite without acknowledge
    send_frame(32'h12345, 20);
    @(negedge clk);
    chk("ovr_first_dv", bus.data_valid, 32'h1);
    send_frame(32'h6789A, 20);
    @(negedge clk);
    chk("ovr_pout", bus.parallel_output, 32'h6789A);
    chk("ovr_set",  bus.overrun,         32'h1);
    chk("ovr_dv",   bus.data_valid,      32'h1);

    // Dropping enable clears overrun
    bus.enable   = 1'b0;
    bus.data_ack = 1'b1;
    @(negedge clk);
    chk("ovr_clear", bus.overrun,    32'h0);
    chk("ovr_ackdv", bus.data_valid, 32'h0);
    bus.enable   = 1'b1;
    bus.data_ack = 1'b0;
    @(negedge clk);

    // Same two frames with an acknowledge between them
    send_frame(32'h12345, 20);
    @(negedge clk);
    chk("ack_first_dv", bus.data_valid, 32'h1);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    chk("ack_mid_dv", bus.data_valid, 32'h0);
    send_frame(32'h6789A, 20);
    @(negedge clk);
    chk("ack_pout", bus.parallel_output, 32'h6789A);
    chk("ack_ov",   bus.overrun,         32'h0);
    chk("ack_dv2",  bus.data_valid,      32'h1);

    // Acknowledge coinciding with the load: the load wins
    send_frame(32'h0000F, 20);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    chk("coinc_dv",   bus.data_valid,      32'h1);
    chk("coinc_pout", bus.parallel_output, 32'h0000F);
    chk("coinc_ov",   bus.overrun,         32'h0);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    chk("coinc_ack_dv", bus.data_valid, 32'h0);

    // Enable rising mid-frame: that frame is ignored
    bus.enable = 1'b0;
    @(negedge clk);
    send_bits(32'h15, 5);
    bus.enable = 1'b1;
    send_bits(32'h1234, 15);
    bus.cs_n = 1'b0;
    @(negedge clk);
    chk("midena_fe1", bus.frame_error, 32'h0);
    @(negedge clk);
    chk("midena_fe2",  bus.frame_error, 32'h0);
    chk("midena_dv",   bus.data_valid,  32'h0);
    chk("midena_busy", bus.busy,        32'h0);
    send_frame(32'hFFFFF, 20);
    @(negedge clk);
    chk("midena_pout", bus.parallel_output, 32'hFFFFF);
    chk("midena_dv2",  bus.data_valid,      32'h1);

    // Reset in the middle of a frame
    send_bits(32'h2AF, 10);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pout", bus.parallel_output, 32'h0);
    chk("midrst_dv",   bus.data_valid,      32'h0);
    chk("midrst_fe",   bus.frame_error,     32'h0);
    chk("midrst_ov",   bus.overrun,         32'h0);
    chk("midrst_busy", bus.busy,            32'h0);
    reset = 1'b0;
    send_bits(32'h0DE, 10);
    bus.cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_tail_fe",   bus.frame_error,     32'h0);
    chk("midrst_tail_dv",   bus.data_valid,      32'h0);
    chk("midrst_tail_pout", bus.parallel_output, 32'h0);
    send_frame(32'h00001, 20);
    @(negedge clk);
    chk("midrst_next_pout", bus.parallel_output, 32'h00001);
    chk("midrst_next_dv",   bus.data_valid,      32'h1);

    // Back-to-back frames separated by a single cs_n=0 cycle
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    send_frame(32'h11111, 20);
    send_frame(32'h22222, 20);
    @(negedge clk);
    chk("b2b_pout", bus.parallel_output, 32'h22222);
    chk("b2b_dv",   bus.data_valid,      32'h1);
    chk("b2b_ov",   bus.overrun,         32'h1);
    chk("b2b_fe",   bus.frame_error,     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
